// File: rtl/segmented_crc_check_if.sv
// Word stream and check-result bundle for segmented_crc_check.
// The master drives the received words; the slave (checker) returns the results.
interface segmented_crc_check_if #(
    parameter int N = 16
);
    logic         In_Valid;
    logic [N-1:0] In;
    logic         In_Last;
    logic         In_Ready;
    logic         Crc_Done;
    logic         Crc_Ok;
    logic [N-1:0] Crc_Calc;
    logic [7:0]   Err_Count;

    modport master (
        output In_Valid, In, In_Last,
        input  In_Ready, Crc_Done, Crc_Ok, Crc_Calc, Err_Count
    );

    modport slave (
        input  In_Valid, In, In_Last,
        output In_Ready, Crc_Done, Crc_Ok, Crc_Calc, Err_Count
    );
endinterface

// File: rtl/segmented_crc_check.sv
// Word-serial CRC-16 frame checker: folds payload words into the CRC, compares the trailing word.
// Optional failed-frame counter enabled by defining CRC_CHECK_ERRCNT_EN.
module segmented_crc_check #(
    parameter int            N    = 16,
    parameter logic [N-1:0]  POLY = 16'h1021,
    parameter logic [N-1:0]  INIT = 16'h0000
) (
    input  logic                 Clk,
    input  logic                 Rst,
    segmented_crc_check_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t       state_r;
    logic [N-1:0] crc_r;
    logic [N-1:0] calc_r;
    logic         ok_r;
    logic         done_r;
    logic         ready_r;
    logic         accept_s;
    logic [N-1:0] crc_next_s;

    // One full word step: (CRC ^ word) * x^N mod POLY, MSB first.
    function automatic logic [N-1:0] crc_step(input logic [N-1:0] crc, input logic [N-1:0] word);
        logic [N-1:0] c;
        c = crc ^ word;
        for (int i = 0; i < N; i++) begin
            c = c[N-1] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    assign accept_s   = bus.In_Valid & ready_r;
    assign crc_next_s = crc_step(crc_r, bus.In);

    // Frame FSM: accumulate payload, latch the comparison on the trailing word.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
            crc_r   <= INIT;
            calc_r  <= {N{1'b0}};
            ok_r    <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, ACCUM: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        if (bus.In_Last) begin
                            calc_r  <= crc_r;
                            ok_r    <= (bus.In == crc_r);
                            done_r  <= 1'b1;
                            ready_r <= 1'b0;
                            crc_r   <= INIT;
                            state_r <= CHECK;
                        end else begin
                            crc_r   <= crc_next_s;
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                CHECK: begin
                    ready_r <= 1'b1;
                    crc_r   <= INIT;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    crc_r   <= INIT;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.In_Ready = ready_r;
    assign bus.Crc_Done = done_r;
    assign bus.Crc_Ok   = ok_r;
    assign bus.Crc_Calc = calc_r;

`ifdef CRC_CHECK_ERRCNT_EN
    logic [7:0] err_r;
    logic       fail_s;

    assign fail_s = accept_s & bus.In_Last & (bus.In != crc_r);

    // Saturating count of frames whose trailing word mismatched.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_r <= 8'h00;
        end else if (fail_s && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'h01;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.Err_Count = err_r;
`else
    assign bus.Err_Count = 8'h00;
`endif

endmodule

// File: tb/tb_segmented_crc_check.sv
// Directed self-checking bench for segmented_crc_check (CRC-16/0x1021, seed 0).
module tb_segmented_crc_check;

    logic Clk;
    logic Rst;
    int   checks;
    int   failures;

    segmented_crc_check_if #(.N(16)) bus ();

    segmented_crc_check #(
        .N    (16),
        .POLY (16'h1021),
        .INIT (16'h0000)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

`ifdef CRC_CHECK_ERRCNT_EN
    localparam logic [7:0] ERR_ONE = 8'h01;
    localparam logic [7:0] ERR_FE  = 8'hFE;
    localparam logic [7:0] ERR_FF  = 8'hFF;
`else
    localparam logic [7:0] ERR_ONE = 8'h00;
    localparam logic [7:0] ERR_FE  = 8'h00;
    localparam logic [7:0] ERR_FF  = 8'h00;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic l);
        bus.In_Valid = v;
        bus.In       = w;
        bus.In_Last  = l;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Rst      = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ready", {15'd0, bus.In_Ready}, 16'h0000);
        chk("rst_done",  {15'd0, bus.Crc_Done}, 16'h0000);
        chk("rst_ok",    {15'd0, bus.Crc_Ok},   16'h0000);
        chk("rst_calc",  bus.Crc_Calc,          16'h0000);
        chk("rst_err",   {8'd0, bus.Err_Count}, 16'h0000);
        Rst = 1'b0;
        tick();
        chk("ready_after_rst", {15'd0, bus.In_Ready}, 16'h0001);

        // Frame 1: payload 0001, trailing 1021 -> pass
        drive(1'b1, 16'h0001, 1'b0);
        tick();
        chk("f1_no_early_done", {15'd0, bus.Crc_Done}, 16'h0000);
        drive(1'b1, 16'h1021, 1'b1);
        tick();
        chk("f1_done",  {15'd0, bus.Crc_Done}, 16'h0001);
        chk("f1_calc",  bus.Crc_Calc,          16'h1021);
        chk("f1_ok",    {15'd0, bus.Crc_Ok},   16'h0001);
        chk("f1_ready", {15'd0, bus.In_Ready}, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        chk("f1_done_clr", {15'd0, bus.Crc_Done}, 16'h0000);
        chk("f1_hold",     bus.Crc_Calc,          16'h1021);

        // Frame 2: payload 0000, 0001, trailing 1022 -> fail
        drive(1'b1, 16'h0000, 1'b0);
        tick();
        drive(1'b1, 16'h0001, 1'b0);
        tick();
        drive(1'b1, 16'h1022, 1'b1);
        tick();
        chk("f2_done", {15'd0, bus.Crc_Done}, 16'h0001);
        chk("f2_calc", bus.Crc_Calc,          16'h1021);
        chk("f2_ok",   {15'd0, bus.Crc_Ok},   16'h0000);
        chk("f2_err",  {8'd0, bus.Err_Count}, {8'd0, ERR_ONE});
        drive(1'b0, 16'h0000, 1'b0);
        tick();

        // Frame 3: zero payload, trailing 0000 -> pass against seed
        drive(1'b1, 16'h0000, 1'b1);
        tick();
        chk("f3_done",  {15'd0, bus.Crc_Done}, 16'h0001);
        chk("f3_calc",  bus.Crc_Calc,          16'h0000);
        chk("f3_ok",    {15'd0, bus.Crc_Ok},   16'h0001);
        chk("f3_ready", {15'd0, bus.In_Ready}, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        chk("f3_ready_back", {15'd0, bus.In_Ready}, 16'h0001);
        chk("f3_err",        {8'd0, bus.Err_Count}, {8'd0, ERR_ONE});

        // Frame 4: payload 0002, idle gap with junk on In, trailing 2042 -> pass
        drive(1'b1, 16'h0002, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'hFFFF, 1'b1);
            tick();
            chk("f4_gap_no_done", {15'd0, bus.Crc_Done}, 16'h0000);
        end
        drive(1'b1, 16'h2042, 1'b1);
        tick();
        chk("f4_done", {15'd0, bus.Crc_Done}, 16'h0001);
        chk("f4_calc", bus.Crc_Calc,          16'h2042);
        chk("f4_ok",   {15'd0, bus.Crc_Ok},   16'h0001);
        drive(1'b0, 16'h0000, 1'b0);
        tick();

        // Abort: reset after two payload words
        drive(1'b1, 16'h0005, 1'b0);
        tick();
        drive(1'b1, 16'h0006, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0);
        Rst = 1'b1;
        #1;
        chk("abort_done",  {15'd0, bus.Crc_Done}, 16'h0000);
        chk("abort_ready", {15'd0, bus.In_Ready}, 16'h0000);
        chk("abort_err",   {8'd0, bus.Err_Count}, 16'h0000);
        tick();
        Rst = 1'b0;
        tick();
        chk("abort_no_done", {15'd0, bus.Crc_Done}, 16'h0000);
        drive(1'b1, 16'h0001, 1'b0);
        tick();
        drive(1'b1, 16'h1021, 1'b1);
        tick();
        chk("f5_done", {15'd0, bus.Crc_Done}, 16'h0001);
        chk("f5_calc", bus.Crc_Calc,          16'h1021);
        chk("f5_ok",   {15'd0, bus.Crc_Ok},   16'h0001);
        chk("f5_err",  {8'd0, bus.Err_Count}, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0);
        tick();

        // Back-to-back failing frames, word held valid through CHECK
        drive(1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 254; i++) begin
            tick();
            tick();
        end
        chk("sat_254", {8'd0, bus.Err_Count}, {8'd0, ERR_FE});
        tick();
        chk("b2b_done", {15'd0, bus.Crc_Done}, 16'h0001);
        chk("b2b_ok",   {15'd0, bus.Crc_Ok},   16'h0000);
        tick();
        chk("b2b_gap_done", {15'd0, bus.Crc_Done}, 16'h0000);
        chk("sat_255", {8'd0, bus.Err_Count}, {8'd0, ERR_FF});
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        chk("sat_260", {8'd0, bus.Err_Count}, {8'd0, ERR_FF});
        drive(1'b0, 16'h0000, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
